mult_switch_mb: RTL

- Parametrised multiplier switch for the distribution/reduction fabric, replacing the single-entry stationary switch.
- Holds up to DEPTH stationary operands selected per beat, multiplies them against streaming operands in a MULT_LAT-stage pipeline, and emits signed integer products.
- Adds valid/ready backpressure toward the reduction network and a saturating counter for dropped beats.

---
 rtl/mult_switch_mb_pkg.sv | 32 +++
 rtl/mult_switch_mb_pipe_mult.sv | 85 ++++++++
 rtl/mult_switch_mb.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mult_switch_mb_pkg.sv
// -----------------------------------------------------------------------------
// mult_switch_pkg
//   Shared definitions for the multiplier switch (mult_switch_mb) and its
//   pipelined multiplier (pipe_mult): default widths, the entry-select width
//   helper, the beat classification enum and the drop-counter constants.
// -----------------------------------------------------------------------------
package mult_switch_pkg;

  // Default geometry of the switch.
  localparam int DATA_W_DEF   = 16;
  localparam int OUT_W_DEF    = 32;
  localparam int DEPTH_DEF    = 4;
  localparam int MULT_LAT_DEF = 2;

  // Dropped-beat counter: fixed 8-bit width, saturates at all-ones.
  localparam int                DROP_W   = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  // What an input beat does in a given cycle.
  typedef enum logic [1:0] {
    BEAT_NONE,    // no beat accepted this cycle
    BEAT_LOAD,    // write a stationary operand into the buffer
    BEAT_STREAM,  // streaming operand against a valid buffer entry
    BEAT_DROP     // streaming operand against an invalid entry
  } beat_e;

  // Width of the buffer-entry select; never narrower than one bit.
  function automatic int sel_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mult_switch_mb_pipe_mult.sv
// -----------------------------------------------------------------------------
// pipe_mult
//   Signed A_W x A_W -> 2*A_W multiplier with LAT register stages and a single
//   shared enable. When en_i is low every stage (data and valid) holds, so the
//   block can sit inside a backpressured pipeline. Reusable by other switches.
//
//   LAT == 1 : product registered directly from the inputs.
//   LAT >= 2 : operands registered first, then the product ripples through
//              LAT-1 further registers.
//
// Ports
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   en_i     in   advance all stages
//   valid_i  in   operands on a_i/b_i are a real beat
//   a_i      in   signed operand A
//   b_i      in   signed operand B
//   valid_o  out  product on prod_o is a real result
//   prod_o   out  full-precision signed product
// -----------------------------------------------------------------------------
module pipe_mult #(
  parameter int A_W = 16,
  parameter int LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    valid_i,
  input  logic signed [A_W-1:0]   a_i,
  input  logic signed [A_W-1:0]   b_i,
  output logic                    valid_o,
  output logic signed [2*A_W-1:0] prod_o
);

  localparam int P_W = 2 * A_W;

  if (LAT == 1) begin : g_single
    logic signed [P_W-1:0] prod_q;
    logic                  vld_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        prod_q <= '0;
        vld_q  <= 1'b0;
      end else if (en_i) begin
        // Size casts of signed operands sign-extend before the multiply.
        prod_q <= P_W'(a_i) * P_W'(b_i);
        vld_q  <= valid_i;
      end
    end

    assign prod_o  = prod_q;
    assign valid_o = vld_q;
  end else begin : g_multi
    logic signed [A_W-1:0] a_q;
    logic signed [A_W-1:0] b_q;
    logic                  op_vld_q;
    logic signed [P_W-1:0] prod_q [LAT-1];
    logic [LAT-2:0]        vld_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        a_q      <= '0;
        b_q      <= '0;
        op_vld_q <= 1'b0;
        vld_q    <= '0;
        for (int i = 0; i < LAT - 1; i++) prod_q[i] <= '0;
      end else if (en_i) begin
        a_q       <= a_i;
        b_q       <= b_i;
        op_vld_q  <= valid_i;
        prod_q[0] <= P_W'(a_q) * P_W'(b_q);
        vld_q[0]  <= op_vld_q;
        for (int i = 1; i < LAT - 1; i++) begin
          prod_q[i] <= prod_q[i-1];
          vld_q[i]  <= vld_q[i-1];
        end
      end
    end

    assign prod_o  = prod_q[LAT-2];
    assign valid_o = vld_q[LAT-2];
  end

endmodule

// File: rtl/mult_switch_mb.sv
// -----------------------------------------------------------------------------
// mult_switch_mb
//   Multiplier switch for the distribution/reduction fabric. Holds up to DEPTH
//   stationary operands, multiplies streaming operands against the entry chosen
//   per beat in a MULT_LAT-stage pipeline, and emits sign-extended products
//   with valid/ready backpressure. Streaming beats that hit an invalid entry
//   are dropped and counted in a saturating 8-bit counter.
//
//   Optional build macro MS_ACCUM_EN: an OUT_W wrapping accumulator follows
//   the multiplier; only the product of an i_last beat produces an output
//   (the running sum), after which the accumulator restarts from zero.
//   Latency becomes MULT_LAT+1. Without the macro i_last is ignored.
//
// Ports
//   clk           in   clock
//   rst           in   synchronous active-high reset
//   i_valid       in   input beat valid
//   o_ready       out  switch accepts a beat this cycle
//   i_data        in   signed operand
//   i_stationary  in   1: load i_data into entry i_sel, 0: streaming beat
//   i_sel         in   buffer entry for load or multiply
//   i_clear       in   invalidate all buffer entries (ignores o_ready)
//   i_last        in   last beat of a dot product (MS_ACCUM_EN only)
//   o_valid       out  output valid
//   i_ready       in   downstream ready
//   o_data        out  signed product, or accumulated sum
//   o_drop_cnt    out  saturating count of dropped streaming beats
// -----------------------------------------------------------------------------
module mult_switch_mb
  import mult_switch_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int OUT_W    = OUT_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int SEL_W    = sel_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_stationary,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_clear,
  input  logic              i_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OUT_W-1:0]  o_data,
  output logic [DROP_W-1:0] o_drop_cnt
);

  logic [DATA_W-1:0]   buf_q [DEPTH];
  logic [DEPTH-1:0]    vld_q;
  logic [DROP_W-1:0]   drop_cnt_q;
  logic [DROP_W-1:0]   drop_cnt_d;

  beat_e               beat;
  logic                pipe_en;
  logic                out_valid;
  logic [OUT_W-1:0]    out_data;

  logic                mult_valid;
  logic signed [2*DATA_W-1:0] mult_prod;
  logic [OUT_W-1:0]    prod_ext;

  // The whole pipeline advances unless a result is waiting on a stalled
  // downstream. Input acceptance follows the same condition.
  assign pipe_en = !out_valid || i_ready;
  assign o_ready = pipe_en;

  // Classify the beat. Streams read the valid bits as they stand before the
  // edge, so a stream coinciding with i_clear still sees the old entries.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned and a latch is never inferred.
    beat       = BEAT_NONE;
    drop_cnt_d = drop_cnt_q;
    if (i_valid && pipe_en) begin
      if (i_stationary)      beat = BEAT_LOAD;
      else if (vld_q[i_sel]) beat = BEAT_STREAM;
      else                   beat = BEAT_DROP;
    end
    if (beat == BEAT_DROP && drop_cnt_q != DROP_MAX)
      drop_cnt_d = drop_cnt_q + 1'b1;
  end

  // Stationary buffer and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the operand buffer is small and must read as zero after reset,
      // so it is a reset register array rather than an unreset RAM.
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      vld_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      // NOTE: the later non-blocking write wins, so a load in the same cycle
      // as i_clear leaves exactly the loaded entry valid.
      if (i_clear) vld_q <= '0;
      if (beat == BEAT_LOAD) begin
        buf_q[i_sel] <= i_data;
        vld_q[i_sel] <= 1'b1;
      end
      drop_cnt_q <= drop_cnt_d;
    end
  end

  pipe_mult #(
    .A_W (DATA_W),
    .LAT (MULT_LAT)
  ) u_pipe_mult (
    .clk     (clk),
    .rst     (rst),
    .en_i    (pipe_en),
    .valid_i (beat == BEAT_STREAM),
    .a_i     (i_data),
    .b_i     (buf_q[i_sel]),
    .valid_o (mult_valid),
    .prod_o  (mult_prod)
  );

  // Signed size cast sign-extends the product to the output width.
  assign prod_ext = OUT_W'(mult_prod);

`ifdef MS_ACCUM_EN
  logic [MULT_LAT-1:0] last_q;
  logic [OUT_W-1:0]    acc_q;
  logic [OUT_W-1:0]    acc_sum;
  logic [OUT_W-1:0]    out_data_q;
  logic                out_valid_q;

  // i_last rides alongside the product so it reaches the accumulator with it.
  // Load and dropped beats never set it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
    end else if (pipe_en) begin
      last_q[0] <= i_last && (beat == BEAT_STREAM);
      for (int i = 1; i < MULT_LAT; i++) last_q[i] <= last_q[i-1];
    end
  end

  assign acc_sum = acc_q + prod_ext;

  // Restart from zero on the closing product so the next dot product starts
  // without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (pipe_en) begin
      out_valid_q <= 1'b0;
      if (mult_valid) begin
        if (last_q[MULT_LAT-1]) begin
          out_data_q  <= acc_sum;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
        end else begin
          acc_q <= acc_sum;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`else
  logic unused_last;
  assign unused_last = i_last;

  assign out_valid = mult_valid;
  assign out_data  = prod_ext;
`endif

  assign o_valid    = out_valid;
  assign o_data     = out_data;
  assign o_drop_cnt = drop_cnt_q;

endmodule
